// File: rtl/ddr3_axi_bram_slave_if.sv
// AXI4 bus bundle between the DDR3 application-side masters and the block-RAM slave.
// The slave modport is the memory side; the master modport is the requester side.
interface ddr3_axi_bram_slave_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 512,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/ddr3_axi_bram_slave.sv
// AXI4 slave backed by a simple-dual-port block RAM with independent read and write FSMs.
// Optional random backpressure generator enabled by defining DDR3_SLV_RAND_STALL_EN.
module ddr3_axi_bram_slave #(
  parameter int          ADDR_WIDTH     = 30,
  parameter int          DATA_WIDTH     = 512,
  parameter int          ID_WIDTH       = 4,
  parameter int          MEM_DEPTH_LOG2 = 10,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                 ui_clk,
  input  logic                 ui_clk_sync_rst,
  ddr3_axi_bram_slave_if.slave s_axi
);

  localparam int          STRB_W    = DATA_WIDTH / 8;
  localparam int          OFF       = $clog2(STRB_W);
  localparam int          DEPTH     = 1 << MEM_DEPTH_LOG2;
  localparam logic [2:0]  FULL_SIZE = 3'(OFF);
  localparam logic [1:0]  OKAY      = 2'b00;
  localparam logic [1:0]  SLVERR    = 2'b10;

  typedef logic [MEM_DEPTH_LOG2-1:0] idx_t;

  logic rst;
  assign rst = ui_clk_sync_rst;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic stall;
`ifdef DDR3_SLV_RAND_STALL_EN
  logic [15:0] lfsr;
  always_ff @(posedge ui_clk) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------- write path ----------------
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  w_state_t w_state, w_next;

  logic                aw_rdy, w_rdy, b_vld, aw_hs, w_hs;
  logic [ID_WIDTH-1:0] w_id;
  idx_t                w_idx;
  logic [7:0]          w_len;
  logic [8:0]          w_cnt;
  logic                w_fixed, w_err, w_final;

  assign aw_hs   = s_axi.awvalid && aw_rdy;
  assign w_hs    = s_axi.wvalid && w_rdy;
  assign w_final = (w_cnt == {1'b0, w_len});

  always_ff @(posedge ui_clk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    b_vld  = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        aw_rdy = !rst && !stall;
        if (s_axi.awvalid && aw_rdy) w_next = W_DATA;
      end
      W_DATA: begin
        w_rdy = !rst && !stall;
        if (s_axi.wvalid && w_rdy && w_final) w_next = W_RESP;
      end
      W_RESP: begin
        b_vld = !rst;
        if (s_axi.bready && b_vld) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (rst) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_fixed <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      if (aw_hs) begin
        w_id    <= s_axi.awid;
        w_idx   <= s_axi.awaddr[OFF +: MEM_DEPTH_LOG2];
        w_len   <= s_axi.awlen;
        w_cnt   <= '0;
        w_fixed <= (s_axi.awburst == 2'b00);
        w_err   <= s_axi.awburst[1] || (s_axi.awsize != FULL_SIZE);
      end
      if (w_hs) begin
        w_cnt <= w_cnt + 9'd1;
        if (!w_fixed) w_idx <= w_idx + idx_t'(1);
        if (s_axi.wlast != w_final) w_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge ui_clk) begin
    if (w_hs) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  assign s_axi.awready = aw_rdy;
  assign s_axi.wready  = w_rdy;
  assign s_axi.bvalid  = b_vld;
  assign s_axi.bid     = w_id;
  assign s_axi.bresp   = w_err ? SLVERR : OKAY;

  // ---------------- read path ----------------
  typedef enum logic {R_IDLE, R_BURST} r_state_t;
  r_state_t r_state, r_next;

  logic                  ar_rdy, ar_hs, rd_en, r_vld, pop, head_last;
  logic [ID_WIDTH-1:0]   r_id;
  idx_t                  r_idx;
  logic [7:0]            r_len;
  logic [8:0]            r_issue;
  logic                  r_fixed, r_err;

  logic [DATA_WIDTH-1:0] f_data [2];
  logic [1:0]            f_last;
  logic                  f_wp, f_rp;
  logic [1:0]            f_count;

  assign ar_hs     = s_axi.arvalid && ar_rdy;
  assign rd_en     = (r_state == R_BURST) && (r_issue <= {1'b0, r_len}) && (f_count < 2'd2);
  assign head_last = f_last[f_rp] && (f_count != 2'd0) && !rst;
  assign pop       = r_vld && s_axi.rready;

`ifdef DDR3_SLV_RAND_STALL_EN
  // A beat already presented stays valid; the stall only delays presenting a new head.
  logic r_shown;
  always_ff @(posedge ui_clk) begin
    if (rst) r_shown <= 1'b0;
    else     r_shown <= r_vld && !s_axi.rready;
  end
  assign r_vld = (f_count != 2'd0) && !rst && (!stall || r_shown);
`else
  assign r_vld = (f_count != 2'd0) && !rst;
`endif

  always_ff @(posedge ui_clk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    ar_rdy = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        ar_rdy = !rst && !stall;
        if (s_axi.arvalid && ar_rdy) r_next = R_IDLE == R_IDLE ? R_BURST : R_IDLE;
      end
      R_BURST: begin
        if (pop && head_last) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (rst) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_issue <= '0;
      r_fixed <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_id    <= s_axi.arid;
        r_idx   <= s_axi.araddr[OFF +: MEM_DEPTH_LOG2];
        r_len   <= s_axi.arlen;
        r_issue <= '0;
        r_fixed <= (s_axi.arburst == 2'b00);
        r_err   <= s_axi.arburst[1] || (s_axi.arsize != FULL_SIZE);
      end
      if (rd_en) begin
        r_issue <= r_issue + 9'd1;
        if (!r_fixed) r_idx <= r_idx + idx_t'(1);
      end
    end
  end

  // The FIFO slot doubles as the RAM output register, so a same-edge write is not seen.
  always_ff @(posedge ui_clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) f_data[i] <= '0;
      f_last  <= '0;
      f_wp    <= 1'b0;
      f_rp    <= 1'b0;
      f_count <= '0;
    end else begin
      if (rd_en) begin
        f_data[f_wp] <= mem[r_idx];
        f_last[f_wp] <= (r_issue == {1'b0, r_len});
        f_wp         <= ~f_wp;
      end
      if (pop) f_rp <= ~f_rp;
      f_count <= f_count + 2'(rd_en) - 2'(pop);
    end
  end

  assign s_axi.arready = ar_rdy;
  assign s_axi.rvalid  = r_vld;
  assign s_axi.rdata   = f_data[f_rp];
  assign s_axi.rlast   = head_last;
  assign s_axi.rid     = r_id;
  assign s_axi.rresp   = r_err ? SLVERR : OKAY;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos, s_axi.awaddr,
                           s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos, s_axi.araddr,
                           LFSR_SEED};

endmodule
